fifo_array_ctrl: RTL

Single-clock sequencer for the fifo_array buffer bank feeding the systolic PE array.
- LOAD phase: takes a serial stream of words (valid/ready) and distributes it round-robin into the ARRAY_SIZE FIFOs with one-hot w_en. Word k goes to FIFO k mod ARRAY_SIZE.
- DRAIN phase: issues skewed one-hot-per-column r_en so FIFO i starts i cycles after FIFO 0, which yields the diagonal wavefront the PE array expects.

---
 rtl/fifo_ctrl_pkg.sv | 42 ++++
 rtl/fifo_array_ctrl_skew.sv | 27 ++
 rtl/fifo_array_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the fifo_array sequencer: FSM states, count maxima, one-hot helper.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Default geometry: 9x9 PE array, 9 words per FIFO per tile.
  localparam int ARRAY_SIZE_DEF = 9;
  localparam int ROW_LEN_DEF    = 9;

  // Words accepted per tile, and drain beats per tile, for the default geometry.
  localparam int LOAD_MAX  = ROW_LEN_DEF * ARRAY_SIZE_DEF;
  localparam int DRAIN_MAX = ROW_LEN_DEF + ARRAY_SIZE_DEF - 1;

  // Widest FIFO bank the one-hot helper can address.
  localparam int ONEHOT_W = 64;

  function automatic int load_max(input int n, input int l);
    return n * l;
  endfunction

  function automatic int drain_max(input int n, input int l);
    return l + n - 1;
  endfunction

  // Single bit set at idx; all zero when idx falls outside [0, width).
  function automatic logic [ONEHOT_W-1:0] onehot(input int idx, input int width);
    logic [ONEHOT_W-1:0] v;
    v = '0;
    if (idx >= 0 && idx < width && idx < ONEHOT_W) begin
      v = ONEHOT_W'(1) << idx;
    end
    return v;
  endfunction

endpackage

// File: rtl/fifo_array_ctrl_skew.sv
// Diagonal read-window generator: column i reads while i <= dr_cnt < i+ROW_LEN.
// Latency: purely combinational.
// Backpressure: out_ready low forces every read enable to zero.
module skew_window_gen
  import fifo_ctrl_pkg::*;
#(
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int ROW_LEN    = ROW_LEN_DEF,
  parameter int CNT_W      = 6
) (
  input  logic [CNT_W-1:0]      dr_cnt,
  input  logic                  out_ready,
  output logic [ARRAY_SIZE-1:0] r_en
);

  logic [31:0] cnt_ext;

  assign cnt_ext = 32'(dr_cnt);

  // Column i lags column 0 by i beats and stays open for ROW_LEN beats.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_col
    localparam logic [31:0] LO = 32'(i);
    localparam logic [31:0] HI = 32'(i + ROW_LEN);
    assign r_en[i] = out_ready && (cnt_ext >= LO) && (cnt_ext < HI);
  end

endmodule

// File: rtl/fifo_array_ctrl.sv
// Tile sequencer for fifo_array: round-robin load of a serial stream, then skewed drain.
// Latency: write enable/data one cycle after the input handshake; read enables combinational.
// Backpressure: in_ready follows !full of the selected FIFO; out_ready low freezes the drain.
module fifo_array_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int DATA_SIZE  = 8,
  parameter int ROW_LEN    = ROW_LEN_DEF,
  parameter int FIFO_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_SIZE-1:0]  in_data,
  output logic                  in_ready,
  input  logic                  out_ready,
  input  logic [ARRAY_SIZE-1:0] full,
  input  logic [ARRAY_SIZE-1:0] empty,
  output logic [ARRAY_SIZE-1:0] w_en,
  output logic [DATA_SIZE-1:0]  wr_data,
  output logic [ARRAY_SIZE-1:0] r_en,
  output logic                  busy,
  output logic                  done,
  output logic                  underflow
);

  localparam int LD_MAX = load_max(ARRAY_SIZE, ROW_LEN);
  localparam int DR_MAX = drain_max(ARRAY_SIZE, ROW_LEN);
  localparam int SEL_W  = $clog2(ARRAY_SIZE);
  localparam int LD_W   = $clog2(LD_MAX) + 1;
  localparam int DR_W   = $clog2(DR_MAX) + 1;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(ARRAY_SIZE - 1);
  localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(LD_MAX - 1);
  localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(DR_MAX - 1);

  // A tile row must fit in one FIFO, and the one-hot helper bounds the bank width.
  if (ARRAY_SIZE < 2 || ARRAY_SIZE >= ONEHOT_W || ROW_LEN < 1 || ROW_LEN > FIFO_DEPTH) begin : g_param_err
    $error("fifo_array_ctrl: illegal ARRAY_SIZE/ROW_LEN/FIFO_DEPTH combination");
  end

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      wr_sel_q, wr_sel_d;
  logic [LD_W-1:0]       ld_cnt_q, ld_cnt_d;
  logic [DR_W-1:0]       dr_cnt_q, dr_cnt_d;
  logic [ARRAY_SIZE-1:0] w_en_q, w_en_d;
  logic [DATA_SIZE-1:0]  wr_data_q, wr_data_d;
  logic                  underflow_q, underflow_d;

  logic [ONEHOT_W-1:0]   sel_oh;
  logic                  unused_sel_oh_hi;
  logic                  hs;
  logic                  drain_rdy;
  logic [ARRAY_SIZE-1:0] r_en_int;

  assign sel_oh           = onehot(int'(wr_sel_q), ARRAY_SIZE);
  assign unused_sel_oh_hi = ^sel_oh[ONEHOT_W-1:ARRAY_SIZE];

  // A full target FIFO stalls the stream; the selector is never skipped past it.
  assign in_ready  = (state_q == LOAD) && !full[wr_sel_q];
  assign hs        = in_valid && in_ready;
  assign drain_rdy = out_ready && (state_q == DRAIN);

  skew_window_gen #(
    .ARRAY_SIZE (ARRAY_SIZE),
    .ROW_LEN    (ROW_LEN),
    .CNT_W      (DR_W)
  ) u_skew (
    .dr_cnt    (dr_cnt_q),
    .out_ready (drain_rdy),
    .r_en      (r_en_int)
  );

  assign r_en      = r_en_int;
  assign w_en      = w_en_q;
  assign wr_data   = wr_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign underflow = underflow_q;

  // Next-state, counters and registered write port; write enable defaults to idle each cycle.
  always_comb begin
    state_d     = state_q;
    wr_sel_d    = wr_sel_q;
    ld_cnt_d    = ld_cnt_q;
    dr_cnt_d    = dr_cnt_q;
    w_en_d      = '0;
    wr_data_d   = wr_data_q;
    underflow_d = underflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          wr_sel_d    = '0;
          ld_cnt_d    = '0;
          dr_cnt_d    = '0;
          underflow_d = 1'b0;
        end
      end
      LOAD: begin
        if (hs) begin
          w_en_d    = sel_oh[ARRAY_SIZE-1:0];
          wr_data_d = in_data;
          wr_sel_d  = (wr_sel_q == SEL_LAST) ? '0 : wr_sel_q + SEL_W'(1);
          ld_cnt_d  = ld_cnt_q + LD_W'(1);
          if (ld_cnt_q == LD_LAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Reading an empty FIFO is flagged but the wavefront keeps going.
        if (|(r_en_int & empty)) begin
          underflow_d = 1'b1;
        end
        if (out_ready) begin
          dr_cnt_d = dr_cnt_q + DR_W'(1);
          if (dr_cnt_q == DR_LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers; clear also flushes the FIFO bank externally.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= IDLE;
      wr_sel_q    <= '0;
      ld_cnt_q    <= '0;
      dr_cnt_q    <= '0;
      w_en_q      <= '0;
      wr_data_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_sel_q    <= wr_sel_d;
      ld_cnt_q    <= ld_cnt_d;
      dr_cnt_q    <= dr_cnt_d;
      w_en_q      <= w_en_d;
      wr_data_q   <= wr_data_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
